// File: rtl/match_lives_controller_pkg.sv
// Shared types and helpers for the 2-player match lives controller.
package match_lives_controller_pkg;

    localparam int unsigned LIVES_W = 4;

    typedef logic [1:0] match_state_t;
    localparam match_state_t StIdle     = 2'd0;
    localparam match_state_t StPlaying  = 2'd1;
    localparam match_state_t StResolve  = 2'd2;
    localparam match_state_t StGameOver = 2'd3;

    typedef enum logic [1:0] {WinNone, WinP1, WinP2, WinDraw} winner_t;

    // A hit and a bonus on the same cycle cancel; bonuses saturate at max_lives.
    function automatic logic [LIVES_W-1:0] next_lives(input logic [LIVES_W-1:0] cur,
                                                      input logic hit,
                                                      input logic bonus,
                                                      input logic [LIVES_W-1:0] max_lives);
        if (hit && !bonus) begin
            return cur - 1'b1;
        end else if (bonus && !hit) begin
            return (cur >= max_lives) ? cur : cur + 1'b1;
        end
        return cur;
    endfunction

    function automatic winner_t resolve_winner(input logic [LIVES_W-1:0] l1,
                                               input logic [LIVES_W-1:0] l2);
        if (l1 > l2) begin
            return WinP1;
        end else if (l2 > l1) begin
            return WinP2;
        end
        return WinDraw;
    endfunction

endpackage

// File: rtl/match_lives_controller_if.sv
// Event pulses in, lives/match status out; master drives events, slave is the controller.
interface match_lives_controller_if;
    import match_lives_controller_pkg::*;

    logic               start_match;
    logic               hit_p1;
    logic               hit_p2;
    logic               extra_life_p1;
    logic               extra_life_p2;
    logic               sec_tick;
    logic [LIVES_W-1:0] lives;
    logic [LIVES_W-1:0] lives2;
    logic               invuln_p1;
    logic               invuln_p2;
    logic               match_active;
    logic               game_over;
    winner_t            winner;
    logic [7:0]         time_left;

    modport master (
        output start_match, hit_p1, hit_p2, extra_life_p1, extra_life_p2, sec_tick,
        input  lives, lives2, invuln_p1, invuln_p2, match_active, game_over, winner, time_left
    );

    modport slave (
        input  start_match, hit_p1, hit_p2, extra_life_p1, extra_life_p2, sec_tick,
        output lives, lives2, invuln_p1, invuln_p2, match_active, game_over, winner, time_left
    );

endinterface

// File: rtl/match_lives_controller_invuln_timer.sv
// Post-hit invulnerability window: active_o stays high for exactly CYCLES cycles after start_i.
module match_lives_controller_invuln_timer #(
    parameter int unsigned CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic clear_i,
    output logic active_o
);

    localparam int unsigned CntW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            active_q, active_d;

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (clear_i) begin
            cnt_d    = '0;
            active_d = 1'b0;
        end else if (start_i && !active_q) begin
            cnt_d    = CntW'(CYCLES - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/match_lives_controller.sv
// 2-player lives/invulnerability/match-end controller feeding the win screen.
// Optional round timer enabled by defining MATCH_TIMER_EN.
module match_lives_controller
    import match_lives_controller_pkg::*;
#(
    parameter int unsigned INIT_LIVES    = 3,
    parameter int unsigned MAX_LIVES     = 9,
    parameter int unsigned INVULN_CYCLES = 50_000_000,
    parameter int unsigned MATCH_SECONDS = 120
) (
    input logic                     clk,
    input logic                     reset,
    match_lives_controller_if.slave ctrl
);

    match_state_t       state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d, lives2_q, lives2_d;
    winner_t            winner_q, winner_d;
    logic [7:0]         time_left_q, time_left_d;
    logic               match_active_q, match_active_d;
    logic               game_over_q, game_over_d;

    logic playing, ending, start_acc, timer_expired;
    logic hit1_acc, hit2_acc, bonus1, bonus2;
    logic inv1, inv2;
    logic [7:0] time_left_init;

`ifdef MATCH_TIMER_EN
    assign time_left_init = 8'(MATCH_SECONDS);
    assign timer_expired  = (time_left_q == 8'd0);
`else
    localparam int unsigned unused_match_seconds = MATCH_SECONDS;
    logic unused_sec_tick;
    assign unused_sec_tick = ctrl.sec_tick;
    assign time_left_init  = 8'd0;
    assign timer_expired   = 1'b0;
`endif

    assign playing   = (state_q == StPlaying);
    assign start_acc = ctrl.start_match && ((state_q == StIdle) || (state_q == StGameOver));
    // A registered zero (or expiry) closes the match; events in that cycle are dropped.
    assign ending    = playing && ((lives_q == '0) || (lives2_q == '0) || timer_expired);
    assign hit1_acc  = playing && !ending && ctrl.hit_p1 && !inv1;
    assign hit2_acc  = playing && !ending && ctrl.hit_p2 && !inv2;
    assign bonus1    = playing && !ending && ctrl.extra_life_p1;
    assign bonus2    = playing && !ending && ctrl.extra_life_p2;

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        lives2_d    = lives2_q;
        winner_d    = winner_q;
        time_left_d = time_left_q;
        case (state_q)
            StIdle, StGameOver: begin
                if (start_acc) begin
                    state_d     = StPlaying;
                    lives_d     = LIVES_W'(INIT_LIVES);
                    lives2_d    = LIVES_W'(INIT_LIVES);
                    winner_d    = WinNone;
                    time_left_d = time_left_init;
                end
            end
            StPlaying: begin
                if (ending) begin
                    state_d = StResolve;
                end else begin
                    lives_d  = next_lives(lives_q, hit1_acc, bonus1, LIVES_W'(MAX_LIVES));
                    lives2_d = next_lives(lives2_q, hit2_acc, bonus2, LIVES_W'(MAX_LIVES));
`ifdef MATCH_TIMER_EN
                    if (ctrl.sec_tick && (time_left_q != 8'd0)) begin
                        time_left_d = time_left_q - 8'd1;
                    end
`endif
                end
            end
            StResolve: begin
                winner_d = resolve_winner(lives_q, lives2_q);
                state_d  = StGameOver;
            end
            default: state_d = StIdle;
        endcase
        match_active_d = (state_d == StPlaying);
        game_over_d    = (state_d == StGameOver);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            lives_q        <= '0;
            lives2_q       <= '0;
            winner_q       <= WinNone;
            time_left_q    <= 8'd0;
            match_active_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            lives2_q       <= lives2_d;
            winner_q       <= winner_d;
            time_left_q    <= time_left_d;
            match_active_q <= match_active_d;
            game_over_q    <= game_over_d;
        end
    end

    match_lives_controller_invuln_timer #(
        .CYCLES (INVULN_CYCLES)
    ) u_invuln_p1 (
        .clk      (clk),
        .reset    (reset),
        .start_i  (hit1_acc),
        .clear_i  (!playing),
        .active_o (inv1)
    );

    match_lives_controller_invuln_timer #(
        .CYCLES (INVULN_CYCLES)
    ) u_invuln_p2 (
        .clk      (clk),
        .reset    (reset),
        .start_i  (hit2_acc),
        .clear_i  (!playing),
        .active_o (inv2)
    );

    assign ctrl.lives        = lives_q;
    assign ctrl.lives2       = lives2_q;
    assign ctrl.invuln_p1    = inv1;
    assign ctrl.invuln_p2    = inv2;
    assign ctrl.match_active = match_active_q;
    assign ctrl.game_over    = game_over_q;
    assign ctrl.winner       = winner_q;
    assign ctrl.time_left    = time_left_q;

endmodule

// File: tb/tb_match_lives_controller.sv
// Scoreboard bench for match_lives_controller: directed pulses, expected snapshots queued per cycle.
module tb_match_lives_controller;
    import match_lives_controller_pkg::*;

    localparam int unsigned INV  = 8;
    localparam int unsigned SECS = 5;
`ifdef MATCH_TIMER_EN
    localparam logic [7:0] TL = 8'd5;
`else
    localparam logic [7:0] TL = 8'd0;
`endif

    localparam logic [5:0] P_START = 6'b100000;
    localparam logic [5:0] P_HIT1  = 6'b010000;
    localparam logic [5:0] P_HIT2  = 6'b001000;
    localparam logic [5:0] P_EX1   = 6'b000100;
    localparam logic [5:0] P_EX2   = 6'b000010;
    localparam logic [5:0] P_SEC   = 6'b000001;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] l1;
        logic [3:0] l2;
        logic       i1;
        logic       i2;
        logic       act;
        logic       over;
        logic [1:0] win;
        logic [7:0] tl;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    match_lives_controller_if ctrl ();

    match_lives_controller #(
        .INIT_LIVES    (3),
        .MAX_LIVES     (9),
        .INVULN_CYCLES (INV),
        .MATCH_SECONDS (SECS)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (ctrl)
    );

    task automatic exp_at(input int dc, input string nm, input logic [3:0] l1,
                          input logic [3:0] l2, input logic i1, input logic i2,
                          input logic act, input logic over, input logic [1:0] win,
                          input logic [7:0] tl);
        exp_t e;
        e.cyc = cyc + dc; e.name = nm; e.l1 = l1; e.l2 = l2; e.i1 = i1; e.i2 = i2;
        e.act = act; e.over = over; e.win = win; e.tl = tl;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic [5:0] p);
        {ctrl.start_match, ctrl.hit_p1, ctrl.hit_p2,
         ctrl.extra_life_p1, ctrl.extra_life_p2, ctrl.sec_tick} = p;
        @(posedge clk);
        #1;
        {ctrl.start_match, ctrl.hit_p1, ctrl.hit_p2,
         ctrl.extra_life_p1, ctrl.extra_life_p2, ctrl.sec_tick} = 6'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(6'b0);
    endtask

    // Monitor: compares every queued snapshot on the negedge of its target cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (mon_e.cyc != cyc) begin
                failures++;
                $display("FAIL %s: snapshot for cycle %0d not sampled (now %0d)",
                         mon_e.name, mon_e.cyc, cyc);
            end else if ({ctrl.lives, ctrl.lives2, ctrl.invuln_p1, ctrl.invuln_p2,
                          ctrl.match_active, ctrl.game_over, ctrl.winner, ctrl.time_left} !==
                         {mon_e.l1, mon_e.l2, mon_e.i1, mon_e.i2,
                          mon_e.act, mon_e.over, mon_e.win, mon_e.tl}) begin
                failures++;
                $display({"FAIL %s cyc=%0d got lives=%0d lives2=%0d inv=%b%b act=%b over=%b ",
                          "win=%0d tl=%0d want lives=%0d lives2=%0d inv=%b%b act=%b over=%b ",
                          "win=%0d tl=%0d"},
                         mon_e.name, cyc, ctrl.lives, ctrl.lives2, ctrl.invuln_p1,
                         ctrl.invuln_p2, ctrl.match_active, ctrl.game_over, ctrl.winner,
                         ctrl.time_left, mon_e.l1, mon_e.l2, mon_e.i1, mon_e.i2, mon_e.act,
                         mon_e.over, mon_e.win, mon_e.tl);
            end
        end
    end

    initial begin
        {ctrl.start_match, ctrl.hit_p1, ctrl.hit_p2,
         ctrl.extra_life_p1, ctrl.extra_life_p2, ctrl.sec_tick} = 6'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        exp_at(0, "reset", 0, 0, 0, 0, 0, 0, WinNone, 0);
        exp_at(1, "idle_pulses_ignored", 0, 0, 0, 0, 0, 0, WinNone, 0);
        step(P_HIT1 | P_EX2);

        exp_at(1, "start", 3, 3, 0, 0, 1, 0, WinNone, TL);
        step(P_START);

        // Invulnerability window on player 1
        exp_at(1, "hit1_first", 2, 3, 1, 0, 1, 0, WinNone, TL);
        step(P_HIT1);
        idle(2);
        exp_at(1, "hit1_during_invuln", 2, 3, 1, 0, 1, 0, WinNone, TL);
        step(P_HIT1 | P_START);
        idle(4);
        exp_at(0, "invuln_last_cycle", 2, 3, 1, 0, 1, 0, WinNone, TL);
        idle(1);
        exp_at(0, "invuln_expired", 2, 3, 0, 0, 1, 0, WinNone, TL);
        exp_at(1, "hit1_third", 1, 3, 1, 0, 1, 0, WinNone, TL);
        step(P_HIT1);
        exp_at(1, "extra1_while_invuln", 2, 3, 1, 0, 1, 0, WinNone, TL);
        step(P_EX1);
        exp_at(1, "extra1_again", 3, 3, 1, 0, 1, 0, WinNone, TL);
        step(P_EX1);

        // Player 2 knocked out -> P1 wins
        exp_at(1, "hit2_a", 3, 2, 1, 1, 1, 0, WinNone, TL);
        step(P_HIT2);
        idle(8);
        exp_at(1, "hit2_b", 3, 1, 0, 1, 1, 0, WinNone, TL);
        step(P_HIT2);
        idle(8);
        exp_at(1, "hit2_zero", 3, 0, 0, 1, 1, 0, WinNone, TL);
        step(P_HIT2);
        exp_at(1, "resolve_p1", 3, 0, 0, 1, 0, 0, WinNone, TL);
        exp_at(2, "game_over_p1", 3, 0, 0, 0, 0, 1, WinP1, TL);
        idle(2);
        exp_at(1, "over_ignores_pulses", 3, 0, 0, 0, 0, 1, WinP1, TL);
        step(P_HIT1 | P_HIT2 | P_EX1 | P_EX2 | P_SEC);

        // Simultaneous knock-out -> draw
        exp_at(1, "restart", 3, 3, 0, 0, 1, 0, WinNone, TL);
        step(P_START);
        exp_at(1, "both_hit_a", 2, 2, 1, 1, 1, 0, WinNone, TL);
        step(P_HIT1 | P_HIT2);
        idle(8);
        exp_at(1, "both_hit_b", 1, 1, 1, 1, 1, 0, WinNone, TL);
        step(P_HIT1 | P_HIT2);
        idle(8);
        exp_at(1, "both_zero", 0, 0, 1, 1, 1, 0, WinNone, TL);
        step(P_HIT1 | P_HIT2);
        exp_at(2, "draw", 0, 0, 0, 0, 0, 1, WinDraw, TL);
        idle(2);

        // Bonus saturation, then hit+bonus on the same cycle
        exp_at(1, "restart2", 3, 3, 0, 0, 1, 0, WinNone, TL);
        step(P_START);
        for (int k = 1; k <= 8; k++) begin
            exp_at(1, $sformatf("extra2_%0d", k), 3, ((3 + k) > 9) ? 4'd9 : 4'(3 + k),
                   0, 0, 1, 0, WinNone, TL);
            step(P_EX2);
        end
        exp_at(1, "hit_extra_same", 3, 9, 0, 1, 1, 0, WinNone, TL);
        step(P_HIT2 | P_EX2);
        exp_at(1, "hit2_invuln_ignored", 3, 9, 0, 1, 1, 0, WinNone, TL);
        step(P_HIT2);
`ifndef MATCH_TIMER_EN
        exp_at(1, "sec_tick_ignored", 3, 9, 0, 1, 1, 0, WinNone, 0);
        step(P_SEC);
`endif

        // Reset dominates start and event pulses
        exp_at(1, "reset_mid_match", 0, 0, 0, 0, 0, 0, WinNone, 0);
        reset = 1'b1;
        step(P_START | P_HIT1 | P_EX2);
        reset = 1'b0;
        exp_at(1, "stays_idle", 0, 0, 0, 0, 0, 0, WinNone, 0);
        step(6'b0);

`ifdef MATCH_TIMER_EN
        exp_at(1, "timer_start", 3, 3, 0, 0, 1, 0, WinNone, 8'd5);
        step(P_START);
        exp_at(1, "timer_hit2", 3, 2, 0, 1, 1, 0, WinNone, 8'd5);
        step(P_HIT2);
        for (int k = 1; k <= 5; k++) begin
            exp_at(1, $sformatf("tick_%0d", k), 3, 2, 0, 1, 1, 0, WinNone, 8'(5 - k));
            step(P_SEC);
        end
        exp_at(1, "timer_resolve", 3, 2, 0, 1, 0, 0, WinNone, 8'd0);
        exp_at(2, "timer_over", 3, 2, 0, 0, 0, 1, WinP1, 8'd0);
        idle(2);
`endif

        repeat (3) @(posedge clk);
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d snapshots left unchecked, want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
